// File: rtl/traffic_pkg.sv
// State codes and direction type shared by the traffic sequencer and the downstream lamp decoder.
package traffic_pkg;

  localparam logic [3:0] ST_ALL_RED   = 4'b0000;
  localparam logic [3:0] ST_NS_GREEN  = 4'b0001;
  localparam logic [3:0] ST_NS_YELLOW = 4'b0010;
  localparam logic [3:0] ST_EW_GREEN  = 4'b0100;
  localparam logic [3:0] ST_EW_YELLOW = 4'b1000;
  localparam logic [3:0] ST_NS_PRIO   = 4'b1111;
  localparam logic [3:0] ST_EW_PRIO   = 4'b1110;

  typedef enum logic [3:0] {
    stAllRed   = ST_ALL_RED,
    stNsGreen  = ST_NS_GREEN,
    stNsYellow = ST_NS_YELLOW,
    stEwGreen  = ST_EW_GREEN,
    stEwYellow = ST_EW_YELLOW,
    stNsPrio   = ST_NS_PRIO,
    stEwPrio   = ST_EW_PRIO
  } stateT;

  typedef enum logic {
    NS = 1'b0,
    EW = 1'b1
  } dirT;

  // Bit 0: NS has right of way, bit 1: EW has right of way (normal or priority green).
  function automatic logic [1:0] greenOf(stateT s);
    greenOf = {(s == stEwGreen) || (s == stEwPrio), (s == stNsGreen) || (s == stNsPrio)};
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Per-direction starvation counter: saturating count of Ticks a car has waited, cleared on gaining green.
module wait_counter
  import traffic_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int MAX_CNT = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Tick,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CNT);

  logic [CNT_W-1:0] countReg;

  // Clear wins over increment: the Tick that grants green also sees the car still waiting.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      countReg <= '0;
    end else if (Tick) begin
      if (clr) begin
        countReg <= '0;
      end else if (inc && (countReg < MAX_V)) begin
        countReg <= countReg + 1'b1;
      end
    end
  end

  assign count = countReg;

endmodule

// File: rtl/traffic_state_sequencer.sv
// Fairness-aware NS/EW traffic-light sequencer with green extension and starvation priority.
// Optional EMERGENCY_PREEMPT_EN adds a Preempt input that cuts greens short and holds all-red.
module traffic_state_sequencer
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int MAX_WAIT  = 8,
  parameter int CNT_W     = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Tick,
  input  logic             CarNS,
  input  logic             CarEW,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic             Preempt,
`endif
  output logic [3:0]       State,
  output logic [CNT_W-1:0] Timer
);

  localparam logic [CNT_W-1:0] MIN_G  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_G  = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] YEL_T  = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] ALLR_T = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] MAX_W  = CNT_W'(MAX_WAIT);

  stateT            stateReg;
  dirT              nextDirReg;
  logic [CNT_W-1:0] timerReg;
  logic [CNT_W-1:0] elapsed;
  logic             preempt;
  logic             allRedGo;
  logic [1:0]       carVec;
  logic [1:0]       greenVec;
  logic [1:0]       nextVec;
  logic [1:0]       incVec;
  logic [1:0]       clrVec;
  logic [1:0]       starved;
  logic [CNT_W-1:0] waitCnt [2];

`ifdef EMERGENCY_PREEMPT_EN
  assign preempt = Preempt;
`else
  assign preempt = 1'b0;
`endif

  assign elapsed  = timerReg + 1'b1;
  assign allRedGo = (stateReg == stAllRed) && (elapsed >= ALLR_T) && !preempt;
  assign carVec   = {CarEW, CarNS};
  assign greenVec = greenOf(stateReg);
  assign nextVec  = {nextDirReg == EW, nextDirReg == NS};

  // Index 0 tracks NS, index 1 tracks EW. A direction is only ever granted from ALL_RED.
  for (genvar gi = 0; gi < 2; gi++) begin : g_wait
    assign incVec[gi]  = carVec[gi] && !greenVec[gi];
    assign clrVec[gi]  = allRedGo && nextVec[gi];
    assign starved[gi] = waitCnt[gi] >= MAX_W;

    wait_counter #(
      .CNT_W   (CNT_W),
      .MAX_CNT (MAX_WAIT)
    ) u_wait (
      .Clock  (Clock),
      .Resetn (Resetn),
      .Tick   (Tick),
      .inc    (incVec[gi]),
      .clr    (clrVec[gi]),
      .count  (waitCnt[gi])
    );
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      stateReg   <= stAllRed;
      timerReg   <= '0;
      nextDirReg <= NS;
    end else if (Tick) begin
      // Default: stay and count; every transition below overrides Timer with 0.
      if (timerReg < MAX_G) begin
        timerReg <= elapsed;
      end
      case (stateReg)
        stAllRed: begin
          if (allRedGo) begin
            timerReg <= '0;
            if (nextDirReg == NS) begin
              stateReg <= starved[0] ? stNsPrio : stNsGreen;
            end else begin
              stateReg <= starved[1] ? stEwPrio : stEwGreen;
            end
          end
        end
        stNsGreen: begin
          if (preempt || ((elapsed >= MIN_G) && CarEW &&
                          (!CarNS || (elapsed >= MAX_G) || starved[1]))) begin
            stateReg <= stNsYellow;
            timerReg <= '0;
          end
        end
        stEwGreen: begin
          if (preempt || ((elapsed >= MIN_G) && CarNS &&
                          (!CarEW || (elapsed >= MAX_G) || starved[0]))) begin
            stateReg <= stEwYellow;
            timerReg <= '0;
          end
        end
        stNsPrio: begin
          if (preempt || (elapsed == MIN_G)) begin
            stateReg <= stNsYellow;
            timerReg <= '0;
          end
        end
        stEwPrio: begin
          if (preempt || (elapsed == MIN_G)) begin
            stateReg <= stEwYellow;
            timerReg <= '0;
          end
        end
        stNsYellow, stEwYellow: begin
          if (elapsed >= YEL_T) begin
            stateReg   <= stAllRed;
            timerReg   <= '0;
            nextDirReg <= (nextDirReg == NS) ? EW : NS;
          end
        end
        default: begin
          stateReg <= stAllRed;
          timerReg <= '0;
        end
      endcase
    end
  end

  assign State = stateReg;
  assign Timer = timerReg;

endmodule

// File: tb/tb_traffic_state_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic vs a phase-level model.
module tb_traffic_state_sequencer;

  logic       Clock;
  logic       Resetn;
  logic       Tick;
  logic       CarNS;
  logic       CarEW;
  logic       preemptIn;
  logic [3:0] State;
  logic [3:0] Timer;

  int checks = 0;
  int errors = 0;

`ifdef EMERGENCY_PREEMPT_EN
  logic Preempt;
  assign preemptIn = Preempt;
`else
  assign preemptIn = 1'b0;
`endif

  traffic_state_sequencer dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Tick   (Tick),
    .CarNS  (CarNS),
    .CarEW  (CarEW),
`ifdef EMERGENCY_PREEMPT_EN
    .Preempt(Preempt),
`endif
    .State  (State),
    .Timer  (Timer)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Phase-level model: what kind of light is shown, for which direction, for how long.
  localparam int K_RED = 0, K_GREEN = 1, K_YEL = 2, K_PRIO = 3;
  int mKind = K_RED;
  int mDir  = 0;
  int mTicks = 0;
  int mNext = 0;
  int mWait [2] = '{0, 0};

  function automatic logic [3:0] codeOf(input int kind, input int dir);
    logic [3:0] c;
    case (kind)
      K_GREEN: c = (dir == 1) ? 4'b0100 : 4'b0001;
      K_YEL:   c = (dir == 1) ? 4'b1000 : 4'b0010;
      K_PRIO:  c = (dir == 1) ? 4'b1110 : 4'b1111;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic modelStep();
    int e;
    int o;
    int nk;
    int nd;
    bit car [2];
    bit hasWay;
    if (!Resetn) begin
      mKind = K_RED; mDir = 0; mTicks = 0; mNext = 0; mWait[0] = 0; mWait[1] = 0;
      return;
    end
    if (!Tick) return;
    car[0] = CarNS;
    car[1] = CarEW;
    e  = mTicks + 1;
    nk = mKind;
    nd = mDir;
    o  = 1 - mDir;
    case (mKind)
      K_RED:   if (e >= 1 && !preemptIn) begin nd = mNext; nk = (mWait[nd] >= 8) ? K_PRIO : K_GREEN; end
      K_GREEN: if (preemptIn || (e >= 4 && car[o] && (!car[mDir] || e >= 12 || mWait[o] >= 8))) nk = K_YEL;
      K_PRIO:  if (preemptIn || e == 4) nk = K_YEL;
      default: if (e >= 2) begin nk = K_RED; mNext = 1 - mNext; end
    endcase
    for (int d = 0; d < 2; d++) begin
      hasWay = (mKind == K_GREEN || mKind == K_PRIO) && (mDir == d);
      if (car[d] && !hasWay && mWait[d] < 8) mWait[d]++;
    end
    if (mKind == K_RED && (nk == K_GREEN || nk == K_PRIO)) mWait[nd] = 0;
    mTicks = (nk != mKind) ? 0 : mTicks + 1;
    mKind = nk;
    mDir  = nd;
  endtask

  // Compare process: model advances on each edge, DUT checked 1 time unit later.
  always @(posedge Clock) begin
    modelStep();
    #1;
    chk("model_state", {28'd0, State}, {28'd0, codeOf(mKind, mDir)});
    chk("model_timer", {28'd0, Timer}, (mTicks > 12) ? 32'd12 : mTicks);
  end

  task automatic tick(input int n);
    repeat (n) begin
      Tick = 1'b1;
      @(negedge Clock);
      Tick = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  initial begin
    Resetn = 1'b0; Tick = 1'b0; CarNS = 1'b0; CarEW = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
    Preempt = 1'b0;
`endif
    idle(3);
    chk("reset_state", {28'd0, State}, 32'h0);
    chk("reset_timer", {28'd0, Timer}, 32'd0);
    Resetn = 1'b1;
    tick(1);
    chk("first_green", {28'd0, State}, 32'h1);

    // Drive into NS_YELLOW, then reset mid-phase.
    CarEW = 1'b1;
    tick(3);  chk("ns_min_hold", {28'd0, State}, 32'h1);
    tick(1);  chk("ns_to_yellow", {28'd0, State}, 32'h2);
    tick(1);  chk("yellow_mid_timer", {28'd0, Timer}, 32'd1);
    Resetn = 1'b0; Tick = 1'b1;
    idle(2);
    Tick = 1'b0;
    chk("midphase_rst_state", {28'd0, State}, 32'h0);
    chk("midphase_rst_timer", {28'd0, Timer}, 32'd0);
    Resetn = 1'b1;
    tick(1);  chk("release_green", {28'd0, State}, 32'h1);

    // Empty NS, waiting EW: minimum green then handover.
    CarNS = 1'b0; CarEW = 1'b1;
    tick(4);  chk("gap_yellow", {28'd0, State}, 32'h2);
    tick(2);  chk("gap_allred", {28'd0, State}, 32'h0);
    tick(1);  chk("gap_ew_green", {28'd0, State}, 32'h4);

`ifdef EMERGENCY_PREEMPT_EN
    CarEW = 1'b0;
    tick(1);  chk("pre_timer1", {28'd0, Timer}, 32'd1);
    Preempt = 1'b1;
    tick(1);  chk("pre_yellow", {28'd0, State}, 32'h8);
    tick(2);  chk("pre_allred", {28'd0, State}, 32'h0);
    tick(3);  chk("pre_hold_red", {28'd0, State}, 32'h0);
    Preempt = 1'b0;
    tick(1);  chk("pre_release", {28'd0, State}, 32'h1);
`endif

    // Continuous NS flow starves EW: extension cut at WaitEW=8, then EW priority.
    Resetn = 1'b0; CarNS = 1'b1; CarEW = 1'b1;
    idle(1);
    Resetn = 1'b1;
    tick(1);  chk("starve_entry", {28'd0, State}, 32'h1);
    tick(7);  chk("starve_extend", {28'd0, State}, 32'h1);
    tick(1);  chk("starve_yellow", {28'd0, State}, 32'h2);
    tick(2);  chk("starve_allred", {28'd0, State}, 32'h0);
    tick(1);  chk("ew_prio", {28'd0, State}, 32'he);
    tick(3);  chk("ew_prio_hold", {28'd0, State}, 32'he);
    tick(1);  chk("ew_prio_exit", {28'd0, State}, 32'h8);

    // No traffic: green holds forever, Timer saturates.
    Resetn = 1'b0; CarNS = 1'b0; CarEW = 1'b0;
    idle(1);
    Resetn = 1'b1;
    tick(1);
    tick(30);
    chk("idle_state", {28'd0, State}, 32'h1);
    chk("idle_timer_sat", {28'd0, Timer}, 32'd12);

    // Cycles without Tick change nothing, including the wait counters.
    repeat (100) begin
      CarNS = ($urandom_range(0, 1) == 1);
      CarEW = ($urandom_range(0, 1) == 1);
      @(negedge Clock);
    end
    chk("notick_state", {28'd0, State}, 32'h1);
    chk("notick_timer", {28'd0, Timer}, 32'd12);
    CarNS = 1'b1; CarEW = 1'b1;
    tick(1);  chk("notick_yellow", {28'd0, State}, 32'h2);
    tick(3);  chk("notick_wait_held", {28'd0, State}, 32'h4);

    // Randomized traffic, slow-changing cars so extension and starvation paths occur.
    repeat (3000) begin
      Tick   = ($urandom_range(0, 1) == 1);
      Resetn = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 7) == 0) CarNS = ~CarNS;
      if ($urandom_range(0, 7) == 0) CarEW = ~CarEW;
`ifdef EMERGENCY_PREEMPT_EN
      if ($urandom_range(0, 15) == 0) Preempt = ~Preempt;
`endif
      @(negedge Clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
